// File: rtl/stream_tap_packer.sv
// rtl/stream_tap_packer.sv - per-buffer channel select, decimation and NPACK-beat packing of sample streams
module stream_tap_packer #(
   parameter int NCHAN = 8,
   parameter int NBUF  = 4,
   parameter int NSAMP = 4,
   parameter int SAMPW = 12,
   parameter int SLOTW = 16,
   parameter int NPACK = 2,
   parameter int DECW  = 4,
   parameter int SELW  = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
   input  logic                              aclk,
   input  logic                              reset_i,
   input  logic [NCHAN*NSAMP*SAMPW-1:0]      dat_i,
   input  logic [NBUF*SELW-1:0]              sel_i,
   input  logic [NBUF*DECW-1:0]              decim_i,
   input  logic [NBUF-1:0]                   mode_i,
   input  logic                              cfg_load_i,
   input  logic                              freeze_i,
   output logic [NBUF*NPACK*NSAMP*SLOTW-1:0] buf_tdata_o,
   output logic [NBUF-1:0]                   buf_tvalid_o
);
   localparam int BEATW = NSAMP * SAMPW;
   localparam int OUTW  = NPACK * NSAMP * SLOTW;
   localparam int FW    = $clog2(NPACK + 1);

   for (genvar b = 0; b < NBUF; b++) begin : g_buf
      logic [SELW-1:0]  sel_r;
      logic [DECW-1:0]  decim_r;
      logic [DECW-1:0]  dc;
      logic             mode_r;
      logic [FW-1:0]    fill;
      logic [FW-1:0]    fill_n;
      logic [BEATW-1:0] hold   [NPACK];
      logic [BEATW-1:0] hold_n [NPACK];
      logic [BEATW-1:0] beat;
      logic [OUTW-1:0]  word_n;
      logic [OUTW-1:0]  tdata_r;
      logic             tvalid_r;
      logic             fire;

      // Out-of-range selects match no channel and leave the beat at zero.
      always_comb begin
         beat = '0;
         for (int c = 0; c < NCHAN; c++) begin
            if (sel_r == SELW'(c)) beat = dat_i[c*BEATW +: BEATW];
         end
      end

      // fill never exceeds NPACK-1 in block mode, so one threshold serves both modes.
      always_comb begin
         for (int k = 0; k < NPACK - 1; k++) hold_n[k] = hold[k+1];
         hold_n[NPACK-1] = beat;
         fire = (fill >= FW'(NPACK - 1));
         if (mode_r && fire)          fill_n = '0;
         else if (fill == FW'(NPACK)) fill_n = fill;
         else                         fill_n = fill + FW'(1);
         word_n = '0;
         for (int k = 0; k < NPACK; k++) begin
            for (int s = 0; s < NSAMP; s++) begin
               word_n[(k*NSAMP + s)*SLOTW + (SLOTW - SAMPW) +: SAMPW] = hold_n[k][s*SAMPW +: SAMPW];
            end
         end
      end

      always_ff @(posedge aclk) begin
         if (reset_i) begin
            sel_r    <= SELW'(b % NCHAN);
            decim_r  <= '0;
            mode_r   <= 1'b0;
            dc       <= '0;
            fill     <= '0;
            tvalid_r <= 1'b0;
            tdata_r  <= '0;
            for (int k = 0; k < NPACK; k++) hold[k] <= '0;
         end else if (cfg_load_i) begin
            sel_r    <= sel_i[b*SELW +: SELW];
            decim_r  <= decim_i[b*DECW +: DECW];
            mode_r   <= mode_i[b];
            dc       <= '0;
            fill     <= '0;
            tvalid_r <= 1'b0;
         end else if (freeze_i) begin
            tvalid_r <= 1'b0;
         end else begin
            dc       <= (dc == decim_r) ? '0 : dc + DECW'(1);
            tvalid_r <= 1'b0;
            if (dc == '0) begin
               for (int k = 0; k < NPACK; k++) hold[k] <= hold_n[k];
               fill <= fill_n;
               if (fire) begin
                  tvalid_r <= 1'b1;
                  tdata_r  <= word_n;
               end
            end
         end
      end

      assign buf_tdata_o[b*OUTW +: OUTW] = tdata_r;
      assign buf_tvalid_o[b]             = tvalid_r;
   end

endmodule
